// File: rtl/cordic_pkg.sv
// Shared types and constants for the sequential vectoring CORDIC.
// Build option CORDIC_GAIN_COMP_EN enables the gain-compensation multiply.
package cordic_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_ANGW  = 32;
    localparam int DEF_NITER = 24;
    localparam int DEF_ADDRW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        GAIN = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Quadrant pre-rotation angles in 9.24 signed degrees.
    localparam logic signed [DEF_ANGW:0] ANG_P90 = 33'sh0_5A00_0000;
    localparam logic signed [DEF_ANGW:0] ANG_M90 = 33'sh1_A600_0000;

    // round(0.607253 * 2^16): reciprocal of the CORDIC gain.
    localparam logic [16:0] INV_K = 17'd39797;

endpackage

// File: rtl/cordic_gain_comp.sv
// Constant multiply by 1/K, used only when CORDIC_GAIN_COMP_EN is defined.
// The input is a non-negative modulus, so it is treated as unsigned.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int XW = DEF_WIDTH + 2
) (
    input  logic signed [XW-1:0] x,
    output logic signed [XW-1:0] scaled
);

    localparam int PW = XW + 17;

    // Product with INV_K, keeping bits [XW+15:16].
    always_comb begin
        scaled = signed'(XW'((PW'(unsigned'(x)) * PW'(INV_K)) >> 16));
    end

endmodule

// File: rtl/cordic_vec_seq.sv
// Sequential vectoring-mode CORDIC: (x,y) -> modulus and phase, one step per clock.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that removes the K scaling.
module cordic_vec_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ANGW  = DEF_ANGW,
    parameter int NITER = DEF_NITER,
    parameter int ADDRW = DEF_ADDRW
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [ANGW-1:0]         rom_data,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH+1:0]        mod_out,
    output logic signed [ANGW:0]    angle_out
);

    localparam int XW = WIDTH + 2;
    localparam int ZW = ANGW + 1;
    localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(NITER - 1);

    state_t                 state_r;
    logic [ADDRW-1:0]       i_r;
    logic signed [XW-1:0]   x_r;
    logic signed [XW-1:0]   y_r;
    logic signed [ZW-1:0]   z_r;
    logic                   zero_r;
    logic                   busy_r;
    logic                   done_r;
    logic [WIDTH+1:0]       mod_r;
    logic signed [ZW-1:0]   angle_r;

    logic signed [XW-1:0]   x_ext_s;
    logic signed [XW-1:0]   y_ext_s;
    logic signed [XW-1:0]   x_sh_s;
    logic signed [XW-1:0]   y_sh_s;
    logic signed [ZW-1:0]   rom_ext_s;

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW-1:0]   x_gain_s;

    cordic_gain_comp #(.XW(XW)) u_gain_comp (
        .x      (x_r),
        .scaled (x_gain_s)
    );
`endif

    // Sign extension of inputs and ROM word, and the per-step shifted terms.
    always_comb begin
        x_ext_s   = XW'(x_in);
        y_ext_s   = XW'(y_in);
        x_sh_s    = x_r >>> i_r;
        y_sh_s    = y_r >>> i_r;
        rom_ext_s = ZW'(signed'(rom_data));
    end

    // Control FSM and datapath: pre-rotate on start, iterate, then publish.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            i_r     <= '0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            zero_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mod_r   <= '0;
            angle_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    i_r <= '0;
                    if (start) begin
                        busy_r  <= 1'b1;
                        state_r <= ITER;
                        // A zero vector has no defined phase; report 0.
                        zero_r  <= (x_in == '0) && (y_in == '0);
                        if (!x_in[WIDTH-1]) begin
                            x_r <= x_ext_s;
                            y_r <= y_ext_s;
                            z_r <= '0;
                        end else if (!y_in[WIDTH-1]) begin
                            x_r <= y_ext_s;
                            y_r <= -x_ext_s;
                            z_r <= ZW'(ANG_P90);
                        end else begin
                            x_r <= -y_ext_s;
                            y_r <= x_ext_s;
                            z_r <= ZW'(ANG_M90);
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ITER: begin
                    if (!y_r[XW-1]) begin
                        x_r <= x_r + y_sh_s;
                        y_r <= y_r - x_sh_s;
                        z_r <= z_r + rom_ext_s;
                    end else begin
                        x_r <= x_r - y_sh_s;
                        y_r <= y_r + x_sh_s;
                        z_r <= z_r - rom_ext_s;
                    end
                    if (i_r == LAST_IDX) begin
                        i_r <= '0;
`ifdef CORDIC_GAIN_COMP_EN
                        state_r <= GAIN;
`else
                        state_r <= OUT;
`endif
                    end else begin
                        i_r <= i_r + 1'b1;
                    end
                end
                GAIN: begin
`ifdef CORDIC_GAIN_COMP_EN
                    x_r <= x_gain_s;
`endif
                    state_r <= OUT;
                end
                OUT: begin
                    mod_r   <= x_r[WIDTH+1:0];
                    angle_r <= zero_r ? '0 : z_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    i_r     <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = i_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign mod_out   = mod_r;
    assign angle_out = angle_r;

endmodule

// File: tb/tb_cordic_vec_seq.sv
// Directed-vector bench for cordic_vec_seq with an external atan ROM model.
// Honours CORDIC_GAIN_COMP_EN for expected modulus and latency.
module tb_cordic_vec_seq;

    localparam int WIDTH = 16;
    localparam int ANGW  = 32;
    localparam int NITER = 24;
    localparam int ADDRW = 6;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = NITER + 3;
    localparam bit GC  = 1'b1;
`else
    localparam int LAT = NITER + 2;
    localparam bit GC  = 1'b0;
`endif
    localparam longint ANG_TOL = 64'd2097152;
    localparam longint MOD_TOL = 64'd16;

    logic                    clock;
    logic                    reset;
    logic                    start;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic [ADDRW-1:0]        rom_addr;
    logic [ANGW-1:0]         rom_data;
    logic                    busy;
    logic                    done;
    logic [WIDTH+1:0]        mod_out;
    logic signed [ANGW:0]    angle_out;

    logic [ANGW-1:0] rom [0:63];
    int total = 0;
    int bad   = 0;

    cordic_vec_seq #(.WIDTH(WIDTH), .ANGW(ANGW), .NITER(NITER), .ADDRW(ADDRW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .done      (done),
        .mod_out   (mod_out),
        .angle_out (angle_out)
    );

    assign rom_data = rom[rom_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input longint got, input longint exp,
                             input longint tol);
        longint d;
        total++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Ideal-arithmetic reference of the vectoring algorithm on wide integers.
    function automatic void model(input int xv, input int yv,
                                  output longint m, output longint a);
        longint xx, yy, zz, dx, dy;
        if (xv >= 0) begin
            xx = xv; yy = yv; zz = 0;
        end else if (yv >= 0) begin
            xx = yv; yy = -xv; zz = 64'd90 * 64'd16777216;
        end else begin
            xx = -yv; yy = xv; zz = -(64'd90 * 64'd16777216);
        end
        for (int i = 0; i < NITER; i++) begin
            dx = yy >>> i;
            dy = xx >>> i;
            if (yy >= 0) begin
                xx = xx + dx; yy = yy - dy; zz = zz + longint'(rom[i]);
            end else begin
                xx = xx - dx; yy = yy + dy; zz = zz - longint'(rom[i]);
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        xx = (xx * 64'd39797) >>> 16;
`endif
        if (xv == 0 && yv == 0) zz = 0;
        m = xx;
        a = zz;
    endfunction

    task automatic run(input int xv, input int yv, input int hold, input bit perturb,
                       input bit chk_addr, output longint m, output longint a);
        int cnt, addr_err, extra;
        bit seen;
        @(negedge clock);
        x_in  = 16'(xv);
        y_in  = 16'(yv);
        start = 1'b1;
        cnt = 0; seen = 1'b0; addr_err = 0; m = 0; a = 0;
        while (!seen && cnt < 60) begin
            @(negedge clock);
            cnt++;
            if (cnt >= hold) start = 1'b0;
            if (perturb && cnt == 5) begin
                x_in = -16'sd5;
                y_in = 16'sd77;
            end
            if (cnt == 1) check_val("busy_after_start", longint'(busy), 64'd1, 64'd0);
            if (chk_addr && cnt <= NITER && rom_addr != ADDRW'(cnt - 1)) addr_err++;
            if (chk_addr && cnt == NITER + 1 && rom_addr != '0) addr_err++;
            if (done) begin
                seen = 1'b1;
                m = longint'(mod_out);
                a = longint'(angle_out);
                check_val("busy_at_done", longint'(busy), 64'd0, 64'd0);
            end
        end
        start = 1'b0;
        check_val("latency", longint'(cnt), longint'(LAT), 64'd0);
        if (chk_addr) check_val("rom_addr_seq", longint'(addr_err), 64'd0, 64'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clock);
            if (done) extra++;
        end
        check_val("single_done", longint'(extra), 64'd0, 64'd0);
    endtask

    task automatic vec(input int xv, input int yv, input longint k_mod, input longint g_mod,
                       input longint ang, input int hold, input bit perturb, input bit chk_addr);
        longint m, a, em, ea;
        run(xv, yv, hold, perturb, chk_addr, m, a);
        model(xv, yv, em, ea);
        check_val($sformatf("mod_model(%0d,%0d)", xv, yv), m, em, 64'd0);
        check_val($sformatf("ang_model(%0d,%0d)", xv, yv), a, ea, 64'd0);
        check_val($sformatf("mod_nom(%0d,%0d)", xv, yv), m, GC ? g_mod : k_mod, MOD_TOL);
        check_val($sformatf("ang_nom(%0d,%0d)", xv, yv), a, ang, ANG_TOL);
    endtask

    initial begin
        real v;
        int dones;
        bit hit;
        for (int i = 0; i < 64; i++) begin
            if (i < NITER) begin
                v = $atan(1.0 / (2.0 ** i)) * 180.0 / 3.14159265358979 * 16777216.0;
                rom[i] = 32'($rtoi(v + 0.5));
            end else begin
                rom[i] = '0;
            end
        end

        reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clock);
        check_val("rst_busy", longint'(busy), 64'd0, 64'd0);
        check_val("rst_done", longint'(done), 64'd0, 64'd0);
        check_val("rst_addr", longint'(rom_addr), 64'd0, 64'd0);
        check_val("rst_mod", longint'(mod_out), 64'd0, 64'd0);
        check_val("rst_angle", longint'(angle_out), 64'd0, 64'd0);
        reset = 1'b0;

        vec(1000, 0, 1647, 1000, 0, 1, 1'b0, 1'b1);
        vec(1000, 1000, 2329, 1414, 754974720, 10, 1'b1, 1'b0);
        vec(0, 1000, 1647, 1000, 1509949440, 1, 1'b0, 1'b0);
        vec(-1000, 0, 1647, 1000, 64'd3019898880, 1, 1'b0, 1'b0);
        vec(-1000, -1, 1647, 1000, -64'sd3018937612, 1, 1'b0, 1'b0);
        vec(-32768, -32768, 76316, 46341, -64'sd2264924160, 1, 1'b0, 1'b0);
        check_val("no_overflow_msb", longint'(mod_out[WIDTH+1]), 64'd0, 64'd0);
        vec(0, 0, 0, 0, 0, 1, 1'b0, 1'b0);

        // Abort a conversion partway through with reset.
        @(negedge clock);
        x_in = 16'sd500; y_in = 16'sd300; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (rom_addr == 6'd10) hit = 1'b1;
            else @(negedge clock);
        end
        check_val("reach_iter10", longint'(rom_addr), 64'd10, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_val("abort_busy", longint'(busy), 64'd0, 64'd0);
        check_val("abort_done", longint'(done), 64'd0, 64'd0);
        check_val("abort_addr", longint'(rom_addr), 64'd0, 64'd0);
        check_val("abort_mod", longint'(mod_out), 64'd0, 64'd0);
        check_val("abort_angle", longint'(angle_out), 64'd0, 64'd0);
        dones = 0;
        repeat (30) begin
            @(negedge clock);
            if (done) dones++;
        end
        check_val("abort_no_done", longint'(dones), 64'd0, 64'd0);

        vec(300, -400, 823, 500, -64'sd891375197, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
